reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter SP_INIT, default 227, 32-bit reset value of register 29 ($sp).
REQ-002 Parameter RA_INIT, default 0, 32-bit reset value of register 31 ($ra).
REQ-003 clk  input  1  single clock; all register updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 RegWrite  input  1  write enable for the write port.
REQ-006 WriteReg  input  32  destination register number from the RegDst selection path; only bits [4:0] used, bits [31:5] ignored.
REQ-007 WriteData  input  32  data written to WriteReg.
REQ-008 ReadReg1  input  5  read port 1 register number.
REQ-009 ReadReg2  input  5  read port 2 register number.
REQ-010 ReadData1  output  32  contents of ReadReg1.
REQ-011 ReadData2  output  32  contents of ReadReg2.

Function
REQ-012 Storage SHALL be 32 registers of 32 bits, r0..r31.
REQ-013 Write SHALL occur on rising clk when reset=1 and RegWrite=1: r[WriteReg[4:0]] <= WriteData; no other register changes.
REQ-014 RegWrite=0 SHALL leave all registers unchanged regardless of WriteReg/WriteData.
REQ-015 r0 SHALL read 0 at all times; writes to index 0 are discarded.
REQ-016 Reads SHALL be combinational from stored state; zero-cycle latency from ReadRegN change to ReadDataN.
REQ-017 Both read ports SHALL be independent; same index on both ports returns identical data.
REQ-018 Without bypass (see REQ-024), a read of the register being written SHALL return the old value until the edge, new value after it.
REQ-019 WriteReg[31:5] nonzero SHALL still write r[WriteReg[4:0]] (wrap modulo 32), no error indication.
REQ-020 Write of index 29 or 31 SHALL behave as any other register; SP_INIT/RA_INIT apply only at reset.

Reset
REQ-021 reset=0 SHALL immediately, independent of clk, set r29=SP_INIT, r31=RA_INIT, all other registers 0; ReadDataN reflect this combinationally.
REQ-022 While reset=0, writes SHALL be suppressed even if RegWrite=1 at a clk edge.
REQ-023 Reset assertion mid-write (same cycle as RegWrite=1) SHALL yield reset values; no partial write survives.

Configuration
REQ-024 Macro REGBANK_BYPASS_EN: when defined, if RegWrite=1, reset=1, WriteReg[4:0]!=0 and ReadRegN==WriteReg[4:0], ReadDataN SHALL equal WriteData combinationally in that cycle; when not defined, REQ-018 applies and no bypass logic exists.
REQ-025 With REGBANK_BYPASS_EN defined, index 0 SHALL never be bypassed; ReadDataN stays 0.

Verification
REQ-026 Reset: drive reset=0 mid-cycle, read 29, 31, 5 -> 227 (0x000000E3), 0, 0 with no clk edge required.
REQ-027 Write/read: RegWrite=1, WriteReg=8, WriteData=0xDEADBEEF, one edge; ReadReg1=8, ReadReg2=8 -> both 0xDEADBEEF; r9 still 0.
REQ-028 Zero register: write 0x12345678 to index 0 -> ReadData1 with ReadReg1=0 returns 0 after the edge.
REQ-029 Wrap/upper bits: WriteReg=0x00000023 (35), WriteData=0xA5A5A5A5 -> r3=0xA5A5A5A5; RegWrite=0 with WriteReg=3, WriteData=0 -> r3 unchanged.
REQ-030 Same-cycle read/write of r31 with old value 0x10, WriteData=0x20: macro undefined -> ReadData1=0x10 before edge, 0x20 after; macro defined -> 0x20 before edge.
REQ-031 Reset during write: r4=0x55, RegWrite=1, WriteReg=4, WriteData=0x77, reset=0 across the edge -> r4=0 after edge and after reset release.

Source files
------------

// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
//   General-purpose register file: 32 registers of 32 bits.
//   One synchronous write port and two independent combinational read ports.
//   r0 is hardwired to zero. r29 ($sp) and r31 ($ra) have their own reset
//   values; every other register resets to zero.
//
// Configuration macro:
//   REGBANK_BYPASS_EN - when defined, a read of the register being written in
//                       the current cycle returns WriteData (write-to-read
//                       forwarding). r0 is never forwarded. When undefined,
//                       no forwarding logic is built and reads always return
//                       the stored value.
//
// Parameters:
//   SP_INIT   reset value of r29
//   RA_INIT   reset value of r31
//
// Ports:
//   clk        in   1   clock; registers update on the rising edge
//   reset      in   1   asynchronous reset, active low
//   RegWrite   in   1   write enable
//   WriteReg   in   32  destination register; only bits [4:0] are used
//   WriteData  in   32  write data
//   ReadReg1   in   5   read port 1 register number
//   ReadReg2   in   5   read port 2 register number
//   ReadData1  out  32  contents of ReadReg1
//   ReadData2  out  32  contents of ReadReg2
// -----------------------------------------------------------------------------
module reg_bank #(
    parameter logic [31:0] SP_INIT = 32'd227,
    parameter logic [31:0] RA_INIT = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [31:0] WriteReg,
    input  logic [31:0] WriteData,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2
);

    localparam logic [4:0] SP_IDX = 5'd29;
    localparam logic [4:0] RA_IDX = 5'd31;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [4:0]  wr_idx;
    logic        wr_en;
    logic [31:0] rd1;
    logic [31:0] rd2;

    // The upper bits of WriteReg come from a full-width mux upstream and are
    // deliberately ignored; the index wraps modulo 32.
    logic        unused_wr_upper;
    assign unused_wr_upper = ^WriteReg[31:5];

    assign wr_idx = WriteReg[4:0];
    // Writes to r0 are dropped here so r0 storage never leaves zero.
    assign wr_en  = RegWrite && (wr_idx != 5'd0);

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[wr_idx] = WriteData;
        end
        regs_d[0] = '0;
    end

    // Reset wins over a same-cycle write, so no partial write survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                if (5'(i) == SP_IDX) begin
                    regs_q[i] <= SP_INIT;
                end else if (5'(i) == RA_IDX) begin
                    regs_q[i] <= RA_INIT;
                end else begin
                    regs_q[i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef REGBANK_BYPASS_EN
    logic byp_en;
    // Forwarding only while out of reset, since a write during reset is
    // suppressed; wr_en already excludes r0.
    assign byp_en = wr_en && reset;

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ReadReg1 != 5'd0) begin
            rd1 = regs_q[ReadReg1];
        end
        if (ReadReg2 != 5'd0) begin
            rd2 = regs_q[ReadReg2];
        end
        if (byp_en && (ReadReg1 == wr_idx)) begin
            rd1 = WriteData;
        end
        if (byp_en && (ReadReg2 == wr_idx)) begin
            rd2 = WriteData;
        end
    end
`else
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ReadReg1 != 5'd0) begin
            rd1 = regs_q[ReadReg1];
        end
        if (ReadReg2 != 5'd0) begin
            rd2 = regs_q[ReadReg2];
        end
    end
`endif

    assign ReadData1 = rd1;
    assign ReadData2 = rd2;

endmodule

// File: tb/tb_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_reg_bank
//   Self-checking bench for reg_bank: directed scenarios with literal
//   expectations, then randomized traffic checked every cycle against an
//   array model of the register file. Honors REGBANK_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [31:0] WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    logic [31:0] m [32];

    always #5 clk = ~clk;

    reg_bank dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: reset values, writes land on the masked index, r0 never written.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m[i] = 32'd0;
            m[29] = 32'd227;
            m[31] = 32'd0;
        end else if (RegWrite && (WriteReg % 32) != 0) begin
            m[WriteReg % 32] = WriteData;
        end
    end

    function automatic logic [31:0] expect_rd(input logic [4:0] rr);
`ifdef REGBANK_BYPASS_EN
        if (RegWrite && reset && (WriteReg % 32) != 0 && rr == WriteReg % 32)
            return WriteData;
`endif
        if (rr == 0) return 32'd0;
        return m[rr];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_rd1", ReadData1, expect_rd(ReadReg1));
            chk("model_rd2", ReadData2, expect_rd(ReadReg2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        RegWrite  = 1'b0;
        WriteReg  = 32'd0;
        WriteData = 32'd0;
        ReadReg1  = 5'd29;
        ReadReg2  = 5'd31;

        // Asynchronous reset between edges; values visible with no edge.
        #3 reset = 1'b0;
        #1;
        chk("rst_r29", ReadData1, 32'h0000_00E3);
        chk("rst_r31", ReadData2, 32'h0000_0000);
        ReadReg1 = 5'd5;
        #1;
        chk("rst_r5", ReadData1, 32'h0000_0000);
        cmp_en = 1'b1;

        // Write attempted while reset held low is suppressed.
        RegWrite = 1'b1; WriteReg = 32'd7; WriteData = 32'hCAFE_0007;
        tick();
        RegWrite = 1'b0; ReadReg1 = 5'd7;
        #1;
        chk("rst_no_write", ReadData1, 32'd0);
        reset = 1'b1;
        tick();

        // Basic write/read on both ports.
        RegWrite = 1'b1; WriteReg = 32'd8; WriteData = 32'hDEAD_BEEF;
        tick();
        RegWrite = 1'b0; ReadReg1 = 5'd8; ReadReg2 = 5'd8;
        #1;
        chk("wr8_rd1", ReadData1, 32'hDEAD_BEEF);
        chk("wr8_rd2", ReadData2, 32'hDEAD_BEEF);
        ReadReg2 = 5'd9;
        #1;
        chk("r9_zero", ReadData2, 32'd0);

        // r0 discards writes.
        RegWrite = 1'b1; WriteReg = 32'd0; WriteData = 32'h1234_5678;
        ReadReg1 = 5'd0;
        tick();
        RegWrite = 1'b0;
        #1;
        chk("r0_zero", ReadData1, 32'd0);

        // Upper index bits wrap: 35 -> r3; then a disabled write changes nothing.
        RegWrite = 1'b1; WriteReg = 32'h0000_0023; WriteData = 32'hA5A5_A5A5;
        tick();
        RegWrite = 1'b0; WriteReg = 32'd3; WriteData = 32'd0;
        tick();
        ReadReg1 = 5'd3;
        #1;
        chk("wrap_r3", ReadData1, 32'hA5A5_A5A5);

        // Same-cycle read/write of r31.
        RegWrite = 1'b1; WriteReg = 32'd31; WriteData = 32'h10;
        tick();
        WriteData = 32'h20; ReadReg1 = 5'd31;
        #1;
`ifdef REGBANK_BYPASS_EN
        chk("r31_before_edge", ReadData1, 32'h20);
`else
        chk("r31_before_edge", ReadData1, 32'h10);
`endif
        tick();
        RegWrite = 1'b0;
        #1;
        chk("r31_after_edge", ReadData1, 32'h20);

        // r0 is never forwarded.
        RegWrite = 1'b1; WriteReg = 32'd0; WriteData = 32'hFFFF_FFFF;
        ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        #1;
        chk("r0_no_bypass", ReadData1, 32'd0);
        tick();
        RegWrite = 1'b0;

        // Reset across a write edge: no partial write survives.
        RegWrite = 1'b1; WriteReg = 32'd4; WriteData = 32'h55;
        tick();
        WriteData = 32'h77; reset = 1'b0; ReadReg1 = 5'd4;
        tick();
        chk("rst_mid_write", ReadData1, 32'd0);
        RegWrite = 1'b0; reset = 1'b1;
        tick();
        chk("rst_mid_write_rel", ReadData1, 32'd0);

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 600; n++) begin
            RegWrite  = ($urandom_range(0, 3) != 0);
            WriteReg  = ($urandom_range(0, 3) == 0) ? $urandom
                                                    : $urandom_range(0, 31);
            WriteData = $urandom;
            ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg[4:0]
                                                    : 5'($urandom_range(0, 31));
            ReadReg2  = ($urandom_range(0, 3) == 0) ? WriteReg[4:0]
                                                    : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 60) == 0) reset = 1'b0;
            else reset = 1'b1;
            tick();
        end
        reset    = 1'b1;
        RegWrite = 1'b0;
        tick();
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
